// File: rtl/fpu_pipe.sv
`timescale 1ns/1ps
// fpu_pipe: the FP-side pipeline shell that faces the integer unit.
// It holds the 32 x 32-bit FP register file, selects the ID operands
// (with forwarding), tracks the E1/E2/E3 destination/write-enable status
// and sequences the multicycle div/sqrt stall. The arithmetic itself
// lives in an external unit attached through the arith_* ports.
//
// Ports
//   clk, clrn            clock; asynchronous active-low reset
//   fs, ft, fd, fc       ID source A/B, destination, op code
//   wf, fasmds           ID writes an FP register / is an FP arithmetic op
//   fwdla/fwdlb          forward wmo to operand A/B
//   fwdfa/fwdfb          forward e3d to operand A/B (wins over fwdla/fwdlb)
//   wwfpr, wrn, wmo      lwc1 writeback enable / register / data
//   arith_r              external unit result for the op in E3
//   e1n..e3n, e1w..e3w   destination numbers / write enables per stage
//   stall, st            div/sqrt stall request / start pulse
//   dfb                  selected B operand (swc1 store data)
//   e3d                  E3 result
//   arith_a/b/fc         E1 operands and op code to the external unit
module fpu_pipe #(
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  fs,
    input  logic [4:0]  ft,
    input  logic [4:0]  fd,
    input  logic [2:0]  fc,
    input  logic        wf,
    input  logic        fasmds,
    input  logic        fwdla,
    input  logic        fwdlb,
    input  logic        fwdfa,
    input  logic        fwdfb,
    input  logic        wwfpr,
    input  logic [4:0]  wrn,
    input  logic [31:0] wmo,
    input  logic [31:0] arith_r,
    output logic [4:0]  e1n,
    output logic [4:0]  e2n,
    output logic [4:0]  e3n,
    output logic        e1w,
    output logic        e2w,
    output logic        e3w,
    output logic        stall,
    output logic        st,
    output logic [31:0] dfb,
    output logic [31:0] e3d,
    output logic [31:0] arith_a,
    output logic [31:0] arith_b,
    output logic [2:0]  arith_fc
);

    localparam logic [3:0] CNT_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} div_state_t;

    logic [31:0]      fpr_reg [32];
    logic [1:0][4:0]  rd_addr;
    logic [1:0]       fwdf;
    logic [1:0]       fwdl;
    logic [1:0][31:0] opnd;

    div_state_t  state_reg;
    logic [3:0]  cnt_reg;
    logic        st_reg;
    logic        e1w_reg, e2w_reg, e3w_reg;
    logic [4:0]  e1n_reg, e2n_reg, e3n_reg;
    logic [2:0]  e1fc_reg;
    logic [31:0] e1a_reg, e1b_reg;

    logic id_div;
    logic capture;

    assign e3d = arith_r;

    // Register file is written on the falling edge so that an ID read in
    // the same cycle (sampled at the next rising edge) sees the new value.
    // The E3 write is issued last so it wins a collision with lwc1.
    always_ff @(negedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) begin
                fpr_reg[i] <= '0;
            end
        end else begin
            if (wwfpr) begin
                fpr_reg[wrn] <= wmo;
            end
            if (e3w_reg) begin
                fpr_reg[e3n_reg] <= e3d;
            end
        end
    end

    // Operand select, index 0 = A, index 1 = B.
    assign rd_addr = {ft, fs};
    assign fwdf    = {fwdfb, fwdfa};
    assign fwdl    = {fwdlb, fwdla};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            assign opnd[gi] = fwdf[gi] ? e3d :
                              fwdl[gi] ? wmo : fpr_reg[rd_addr[gi]];
        end
    endgenerate

    assign dfb = opnd[1];

    assign id_div  = fasmds && ((fc == 3'b011) || (fc == 3'b100));
    assign stall   = (state_reg == BUSY) && (cnt_reg != 4'd0);
    assign capture = !stall;

    // Div/sqrt sequencer. Once the counter reaches zero the op leaves E1 on
    // the next edge; a div/sqrt waiting in ID enters on that same edge and
    // restarts the count.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            st_reg    <= 1'b0;
        end else begin
            st_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (id_div) begin
                        state_reg <= BUSY;
                        cnt_reg   <= CNT_LOAD;
                        st_reg    <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else if (id_div) begin
                        cnt_reg <= CNT_LOAD;
                        st_reg  <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Stage registers: E1 holds during a stall and E2 takes a bubble,
    // while E3 keeps draining.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            e1w_reg  <= 1'b0;
            e1n_reg  <= '0;
            e1fc_reg <= '0;
            e1a_reg  <= '0;
            e1b_reg  <= '0;
            e2w_reg  <= 1'b0;
            e2n_reg  <= '0;
            e3w_reg  <= 1'b0;
            e3n_reg  <= '0;
        end else begin
            if (capture) begin
                e1w_reg  <= wf & fasmds;
                e1n_reg  <= fd;
                e1fc_reg <= fc;
                e1a_reg  <= opnd[0];
                e1b_reg  <= opnd[1];
                e2w_reg  <= e1w_reg;
                e2n_reg  <= e1n_reg;
            end else begin
                e2w_reg  <= 1'b0;
                e2n_reg  <= '0;
            end
            e3w_reg <= e2w_reg;
            e3n_reg <= e2n_reg;
        end
    end

    assign e1w      = e1w_reg;
    assign e2w      = e2w_reg;
    assign e3w      = e3w_reg;
    assign e1n      = e1n_reg;
    assign e2n      = e2n_reg;
    assign e3n      = e3n_reg;
    assign st       = st_reg;
    assign arith_a  = e1a_reg;
    assign arith_b  = e1b_reg;
    assign arith_fc = e1fc_reg;

endmodule

// File: tb/tb_fpu_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for fpu_pipe: reset state, a randomized stream of
// pipelined ops checked against a queue-based reference model, a table of
// operand-select vectors, and hand-written multicycle sequences.
module tb_fpu_pipe;

    localparam int DIVC = 4;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [4:0]  fs, ft, fd, wrn;
    logic [2:0]  fc;
    logic        wf, fasmds, fwdla, fwdlb, fwdfa, fwdfb, wwfpr;
    logic [31:0] wmo, arith_r;
    logic [4:0]  e1n, e2n, e3n;
    logic        e1w, e2w, e3w, stall, st;
    logic [31:0] dfb, e3d, arith_a, arith_b;
    logic [2:0]  arith_fc;

    always #5 clk = ~clk;

    fpu_pipe #(.DIV_CYCLES(DIVC)) dut (
        .clk(clk), .clrn(clrn),
        .fs(fs), .ft(ft), .fd(fd), .fc(fc),
        .wf(wf), .fasmds(fasmds),
        .fwdla(fwdla), .fwdlb(fwdlb), .fwdfa(fwdfa), .fwdfb(fwdfb),
        .wwfpr(wwfpr), .wrn(wrn), .wmo(wmo), .arith_r(arith_r),
        .e1n(e1n), .e2n(e2n), .e3n(e3n),
        .e1w(e1w), .e2w(e2w), .e3w(e3w),
        .stall(stall), .st(st), .dfb(dfb), .e3d(e3d),
        .arith_a(arith_a), .arith_b(arith_b), .arith_fc(arith_fc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        fs = 0; ft = 0; fd = 0; fc = 0; wf = 0; fasmds = 0;
        fwdla = 0; fwdlb = 0; fwdfa = 0; fwdfb = 0;
        wwfpr = 0; wrn = 0; wmo = 0; arith_r = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
        #1;
    endtask

    // Reference model: instruction records in pipeline order and the
    // architectural register contents.
    typedef struct {
        logic        w;
        logic [4:0]  n;
        logic [2:0]  fc;
        logic [31:0] a;
        logic [31:0] b;
    } rec_t;

    typedef struct {
        logic        fwdf;
        logic        fwdl;
        logic [31:0] r;
        logic [31:0] m;
        logic [31:0] exp;
    } vec_t;

    rec_t        pipe_q[$];
    rec_t        r;
    logic [31:0] mreg [32];
    vec_t        vecs [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'hAAAA5555, 32'h5555AAAA, 32'h11111111};
        vecs[1] = '{1'b0, 1'b1, 32'h01020304, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[2] = '{1'b1, 1'b0, 32'h0BADC0DE, 32'h77777777, 32'h0BADC0DE};
        vecs[3] = '{1'b1, 1'b1, 32'h87654321, 32'h13572468, 32'h87654321};

        // ---------------- reset state ----------------
        idle_in();
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        half();
        clrn = 1'b1;
        ft = 5'd9;
        #1;
        chk("reset_status", {e1n, e1w, e2n, e2w, e3n, e3w, stall, st}, '0);
        chk("reset_arith", {arith_a, arith_b, arith_fc}, '0);
        chk("reset_dfb", dfb, 32'h0);

        // ---------------- randomized stream vs model ----------------
        // Queue holds [ID, E1, E2, E3] between edges.
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        pipe_q = {};
        r = '{1'b0, 5'd0, 3'd0, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) pipe_q.push_back(r);

        for (int c = 0; c < 250; c++) begin
            tick();
            void'(pipe_q.pop_back());
            chk("rnd_status", {e1n, e1w, e2n, e2w, e3n, e3w, stall, st},
                {pipe_q[0].n, pipe_q[0].w, pipe_q[1].n, pipe_q[1].w,
                 pipe_q[2].n, pipe_q[2].w, 2'b00});
            chk("rnd_e1_operands", {arith_fc, arith_a, arith_b},
                {pipe_q[0].fc, pipe_q[0].a, pipe_q[0].b});

            fs      = 5'($urandom);
            ft      = 5'($urandom);
            fd      = 5'($urandom);
            fasmds  = 1'($urandom);
            wf      = 1'($urandom);
            fc      = fasmds ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            fwdfa   = ($urandom_range(0, 3) == 0);
            fwdfb   = ($urandom_range(0, 3) == 0);
            fwdla   = ($urandom_range(0, 3) == 0);
            fwdlb   = ($urandom_range(0, 3) == 0);
            wwfpr   = 1'($urandom);
            wrn     = 5'($urandom);
            wmo     = $urandom;
            arith_r = $urandom;

            // This cycle's register writes, E3 result taking precedence.
            if (wwfpr) mreg[wrn] = wmo;
            if (pipe_q[2].w) mreg[pipe_q[2].n] = arith_r;

            r.w  = wf & fasmds;
            r.n  = fd;
            r.fc = fc;
            r.a  = fwdfa ? arith_r : (fwdla ? wmo : mreg[fs]);
            r.b  = fwdfb ? arith_r : (fwdlb ? wmo : mreg[ft]);
            pipe_q.push_front(r);

            half();
            chk("rnd_dfb", dfb, r.b);
        end
        idle_in();
        repeat (4) tick();

        // ---------------- operand-select table ----------------
        wwfpr = 1; wrn = 5'd9; wmo = 32'h11111111;
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            fs = 5'd9; ft = 5'd9;
            fwdfa = vecs[i].fwdf; fwdfb = vecs[i].fwdf;
            fwdla = vecs[i].fwdl; fwdlb = vecs[i].fwdl;
            arith_r = vecs[i].r; wmo = vecs[i].m;
            fasmds = 1; wf = 1; fc = 3'b010; fd = 5'(i + 1);
            half();
            chk("vec_dfb", dfb, vecs[i].exp);
            tick();
            chk("vec_e1", {arith_a, arith_b, arith_fc, e1n, e1w},
                {vecs[i].exp, vecs[i].exp, 3'b010, 5'(i + 1), 1'b1});
        end
        idle_in();
        repeat (4) tick();

        // ---------------- lwc1 write then read ----------------
        wwfpr = 1; wrn = 5'd5; wmo = 32'h3F800000; ft = 5'd5;
        half();
        chk("lwc1_same_cycle_dfb", dfb, 32'h3F800000);
        tick();
        idle_in();
        fs = 5'd5;
        tick();
        chk("lwc1_arith_a", arith_a, 32'h3F800000);

        // ---------------- add through the pipe ----------------
        idle_in();
        fasmds = 1; wf = 1; fd = 5'd7; fc = 3'b000;
        tick();
        idle_in();
        chk("add_e1", {e1n, e1w}, {5'd7, 1'b1});
        tick();
        chk("add_e2", {e2n, e2w}, {5'd7, 1'b1});
        tick();
        chk("add_e3", {e3n, e3w}, {5'd7, 1'b1});
        arith_r = 32'h40000000; fs = 5'd7; ft = 5'd7;
        half();
        chk("add_wb_dfb", dfb, 32'h40000000);
        tick();
        arith_r = 32'h0;
        chk("add_wb_arith_a", arith_a, 32'h40000000);
        half();
        chk("add_reg7_kept", dfb, 32'h40000000);

        // ---------------- forwarding priority ----------------
        tick();
        idle_in();
        fwdfa = 1; fwdla = 1; fwdfb = 0; fwdlb = 1;
        arith_r = 32'h12345678; wmo = 32'hDEADBEEF;
        half();
        chk("fwd_dfb_load", dfb, 32'hDEADBEEF);
        tick();
        chk("fwd_arith_ab", {arith_a, arith_b}, {32'h12345678, 32'hDEADBEEF});

        // ---------------- div then back-to-back sqrt ----------------
        idle_in();
        repeat (3) tick();
        fasmds = 1; wf = 1; fd = 5'd12; fc = 3'b011;
        tick();                                    // cycle t
        idle_in();
        fasmds = 1; wf = 1; fd = 5'd13; fc = 3'b100;
        chk("div_t", {st, stall, e1n, e1w, arith_fc}, {1'b1, 1'b1, 5'd12, 1'b1, 3'b011});
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("div_stall_window", {st, stall, e2w, e2n},
                {1'b0, 1'(k <= DIVC - 2), 1'b0, 5'd0});
        end
        tick();                                    // cycle t+4
        idle_in();
        chk("div_e2_sqrt_start", {e2n, e2w, st, stall, e1n},
            {5'd12, 1'b1, 1'b1, 1'b1, 5'd13});
        tick();
        chk("div_e3", {e3n, e3w, stall, st}, {5'd12, 1'b1, 1'b1, 1'b0});
        repeat (3) tick();
        chk("sqrt_e2", {e2n, e2w, stall, st}, {5'd13, 1'b1, 1'b0, 1'b0});

        // ---------------- write collision ----------------
        idle_in();
        repeat (3) tick();
        fasmds = 1; wf = 1; fd = 5'd3; fc = 3'b001;
        tick();
        idle_in();
        repeat (2) tick();
        chk("coll_e3", {e3n, e3w}, {5'd3, 1'b1});
        arith_r = 32'hAAAA0000; wwfpr = 1; wrn = 5'd3; wmo = 32'h55555555; ft = 5'd3;
        half();
        chk("coll_dfb", dfb, 32'hAAAA0000);
        tick();
        idle_in();
        ft = 5'd3;
        half();
        chk("coll_reg3", dfb, 32'hAAAA0000);

        // ---------------- reset in the middle of a div ----------------
        tick();
        idle_in();
        fasmds = 1; wf = 1; fd = 5'd12; fc = 3'b011;
        tick();                                    // cycle t
        idle_in();
        chk("rdiv_start", {st, stall}, {1'b1, 1'b1});
        tick();                                    // cycle t+1
        chk("rdiv_pre", stall, 1'b1);
        clrn = 1'b0;
        #1;
        chk("rdiv_async", {stall, st, e1w, e1n, e2w, e2n, e3w, e3n, arith_a, arith_b, arith_fc}, '0);
        half();
        clrn = 1'b1;
        ft = 5'd9;
        #1;
        chk("rdiv_regfile_cleared", dfb, 32'h0);
        tick();
        chk("rdiv_after", {stall, st, e1w}, '0);
        tick();
        chk("rdiv_after2", {stall, st, e2w}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
